// File: rtl/edge_frame_packer.sv
// Edge pixel packer: thresholds Canny pixels to 1 bit, packs 8 per byte into a frame buffer,
// then drains header, length, payload and XOR checksum over a valid/ready byte interface.
module edge_frame_packer #(
  parameter int         H_RES = 170,
  parameter int         V_RES = 240,
  parameter int         TH    = 128,
  parameter logic [7:0] HDR0  = 8'hAA,
  parameter logic [7:0] HDR1  = 8'h55
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_de,
  input  logic [7:0] i_data,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  input  logic       i_tx_ready,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic       o_overrun
);

  // state     | meaning
  // S_IDLE    | waiting for the first pixel of a frame
  // S_CAPTURE | packing pixels into the frame buffer
  // S_HDR0    | sending first header byte
  // S_HDR1    | sending second header byte
  // S_LENH    | sending payload length, high byte
  // S_LENL    | sending payload length, low byte (buffer byte 0 prefetched)
  // S_PAY     | sending payload bytes in address order
  // S_CSUM    | sending XOR checksum of the payload

  localparam int N   = H_RES * V_RES;
  localparam int L   = (N + 7) / 8;
  localparam int PCW = (N > 1) ? $clog2(N) : 1;
  localparam int AW  = (L > 1) ? $clog2(L) : 1;

  localparam logic [15:0]    LEN       = 16'(L);
  localparam logic [PCW-1:0] LAST_PIX  = PCW'(N - 1);
  localparam logic [AW-1:0]  LAST_ADDR = AW'(L - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_HDR0, S_HDR1, S_LENH, S_LENL, S_PAY, S_CSUM
  } state_t;

  state_t         state, state_nxt;
  logic [PCW-1:0] pix_cnt;
  logic [2:0]     bit_idx;
  logic [AW-1:0]  wr_addr;
  logic [AW-1:0]  pay_addr;
  logic [AW-1:0]  next_addr;
  logic [AW-1:0]  raddr;
  logic [7:0]     acc;
  logic [7:0]     csum;
  logic [7:0]     rdata;
  logic [7:0]     new_byte;
  logic           frame_done;
  logic           overrun;
  logic           hs;
  logic           capturing;
  logic           pix_take;
  logic           pix_bit;
  logic           pix_last;
  logic           byte_end;

  logic [7:0] mem [L];

  assign hs        = o_tx_valid & i_tx_ready;
  assign capturing = (state == S_IDLE) || (state == S_CAPTURE);
  assign pix_take  = i_de & capturing;
  assign pix_bit   = ({1'b0, i_data} >= 9'(TH));
  assign pix_last  = (pix_cnt == LAST_PIX);
  assign byte_end  = (bit_idx == 3'd7) || pix_last;
  assign new_byte  = acc | ({7'd0, pix_bit} << (3'd7 - bit_idx));

  assign next_addr = (pay_addr == LAST_ADDR) ? '0 : pay_addr + 1'b1;
  // Look one address ahead on a payload handshake so the RAM latency adds no bubble.
  assign raddr     = ((state == S_PAY) && hs) ? next_addr : pay_addr;

  assign o_frame_done = frame_done;
  assign o_overrun    = overrun;

  always_ff @(posedge clk) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (i_de) state_nxt = pix_last ? S_HDR0 : S_CAPTURE;
      S_CAPTURE: if (i_de && pix_last) state_nxt = S_HDR0;
      S_HDR0:    if (hs) state_nxt = S_HDR1;
      S_HDR1:    if (hs) state_nxt = S_LENH;
      S_LENH:    if (hs) state_nxt = S_LENL;
      S_LENL:    if (hs) state_nxt = S_PAY;
      S_PAY:     if (hs && (pay_addr == LAST_ADDR)) state_nxt = S_CSUM;
      S_CSUM:    if (hs) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_tx_valid = 1'b0;
    o_tx_data  = 8'h00;
    o_busy     = (state != S_IDLE);
    case (state)
      S_HDR0: begin o_tx_valid = 1'b1; o_tx_data = HDR0;       end
      S_HDR1: begin o_tx_valid = 1'b1; o_tx_data = HDR1;       end
      S_LENH: begin o_tx_valid = 1'b1; o_tx_data = LEN[15:8];  end
      S_LENL: begin o_tx_valid = 1'b1; o_tx_data = LEN[7:0];   end
      S_PAY:  begin o_tx_valid = 1'b1; o_tx_data = rdata;      end
      S_CSUM: begin o_tx_valid = 1'b1; o_tx_data = csum;       end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pix_cnt    <= '0;
      bit_idx    <= '0;
      wr_addr    <= '0;
      pay_addr   <= '0;
      acc        <= 8'h00;
      csum       <= 8'h00;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= (state == S_CSUM) && hs;
      if (i_de && !capturing) overrun <= 1'b1;
      if (pix_take) begin
        if (pix_last) begin
          pix_cnt <= '0;
          bit_idx <= '0;
          wr_addr <= '0;
        end else begin
          pix_cnt <= pix_cnt + 1'b1;
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) wr_addr <= wr_addr + 1'b1;
        end
        acc <= byte_end ? 8'h00 : new_byte;
        if (byte_end) csum <= csum ^ new_byte;
      end else if ((state == S_CSUM) && hs) begin
        csum <= 8'h00;
      end
      if ((state == S_PAY) && hs) pay_addr <= next_addr;
    end
  end

  // Frame buffer: never cleared, read data valid one cycle after raddr.
  always_ff @(posedge clk) begin
    if (pix_take && byte_end) mem[wr_addr] <= new_byte;
    rdata <= mem[raddr];
  end

endmodule

// File: doc/edge_frame_packer.md
# edge_frame_packer

Downstream of the Canny edge stage and upstream of the UART TX FIFO. Thresholds each edge pixel to 1 bit, packs 8 pixels per byte into an internal frame buffer, and drains the buffer as one framed packet over a valid/ready byte interface. The packet is header, length, payload, checksum. The buffer absorbs the full-rate pixel burst, so the slow UART side never drops pixels.

## Interface

Parameters
- H_RES, 170: pixels per line
- V_RES, 240: lines per frame
- TH, 128: pixel value at or above TH packs as bit 1, below packs as 0
- HDR0, 8'hAA: first header byte
- HDR1, 8'h55: second header byte

Ports
- clk, input, 1: the single clock
- rstn, input, 1: reset, synchronous and active-low
- i_de, input, 1: pixel valid from the Canny stage, no backpressure
- i_data, input, 8: edge pixel (R channel of the Canny output)
- o_tx_data, output, 8: packet byte
- o_tx_valid, output, 1: o_tx_data is valid
- i_tx_ready, input, 1: sink accepts a byte (driven by TX FIFO not-full)
- o_busy, output, 1: high in any state other than IDLE
- o_frame_done, output, 1: 1-cycle pulse after the checksum byte is accepted
- o_overrun, output, 1: sticky; set when a pixel arrives during draining

## Operation

- Frame size: N = H_RES*V_RES pixels. Payload length L = ceil(N/8) bytes; the default is 5100 (16'h13EC).
- Bit packing:
  - Packing runs frame-contiguous across line boundaries; there is no per-line padding.
  - The first pixel of each byte goes to bit 7 (MSB first).
  - When N%8≠0, the final byte is padded with zeros in its LSBs.
- Buffer: L×8 RAM with 1-cycle read latency. Each byte is written when its 8th bit (or the final pixel) arrives. The buffer contents are never cleared.
- Packet order is HDR0, HDR1, L[15:8], L[7:0], L payload bytes in address order, then CSUM. CSUM is the XOR of all payload bytes, accumulated during capture.
- States:
  - IDLE: waits for data. An i_de beat here is stored as pixel 0, and the block moves to CAPTURE.
  - CAPTURE: each i_de beat increments the pixel counter. Gaps in i_de are allowed. After pixel N-1 is stored, the block moves to SEND_HDR0.
  - SEND_HDR0 → SEND_HDR1 → SEND_LENH → SEND_LENL → SEND_PAY → SEND_CSUM. Each transition happens on a handshake (o_tx_valid & i_tx_ready).
  - SEND_PAY leaves after byte L-1 is accepted.
  - SEND_CSUM returns to IDLE on acceptance and pulses o_frame_done.
- Overrun:
  - An i_de beat in any SEND_* state is discarded, and o_overrun is set.
  - The packet being sent is unaffected.
  - o_overrun clears only on reset.
- Handshake rules:
  - A byte transfers on a cycle where o_tx_valid & i_tx_ready.
  - While o_tx_valid=1 and i_tx_ready=0, o_tx_data must be held stable and o_tx_valid must stay high.
  - o_tx_valid is never asserted in IDLE or CAPTURE.
- Widths: the pixel counter is clog2(N) bits, the byte address is clog2(L) bits, and the checksum is 8 bits XOR.

## Timing

- Reset: rstn sampled low forces the following on the next edge:
  - state = IDLE
  - o_tx_data = 0, o_tx_valid = 0, o_busy = 0, o_frame_done = 0, o_overrun = 0
  - counters, bit accumulator and CSUM cleared
- Reset mid-capture or mid-send abandons the frame. No partial packet is resumed.
- o_tx_valid rises no later than 2 cycles after pixel N-1 is sampled.
- Throughput: with i_tx_ready held high, the complete packet (L+5 bytes) finishes within 2*(L+5) cycles of the first o_tx_valid. Bubbles between bytes are permitted; only the handshake is checked.
- o_frame_done asserts on the cycle after the CSUM handshake, for exactly 1 cycle. o_busy falls on the same cycle.
- A new frame may start (i_de in IDLE) on the cycle o_frame_done is high.
- Simultaneous events: a pixel arriving on the same cycle as the CSUM handshake counts as overrun, because the state is still SEND_CSUM.

## Test plan

- All-zero frame: 40800 beats, i_data=0, i_tx_ready=1 → stream AA 55 13 EC, 5100×00, 00. Exactly one o_frame_done pulse; o_overrun=0.
- All-255 frame → AA 55 13 EC, 5100×FF, CSUM 00.
- Threshold and bit order: pixel k=128 when k%8==0, pixel k=127 otherwise → payload all 0x80, CSUM 00. Pixel k=200 only at k=7 and all others 0 → byte0=0x01, remaining bytes 00, CSUM 01.
- Backpressure: i_tx_ready random (~30% high), random i_de gaps during capture → the byte sequence is identical to the ready=1 run. o_tx_data is stable whenever valid&!ready.
- Overrun: a second frame's i_de beats during SEND_PAY → o_overrun=1 and the packet is unchanged. After o_frame_done, a fresh frame packs correctly.
- Reset mid-payload: rstn low for 1 cycle at payload byte 100 → all outputs 0 next cycle and o_overrun cleared. The following full frame produces a correct packet.
